// File: rtl/fetch_redirect_control.sv
// fetch_redirect_control
// Holds the IF/ID pipeline register and decodes the instruction in ID.
// Resolves beq/bne/j/jal/jr in ID and drives PCWrite/PCSelector/target to fetch.
// Detects load-use and branch-operand hazards (stall + ID/EX bubble) and
// flushes the wrong-path fetch on a taken redirect.
// Keeps saturating stall and flush event counters for performance debug.
// Jump targets take PC_4[NBits-1:28], so NBits must be at least 32.
module fetch_redirect_control #(
    parameter int NBits    = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBits-1:0]    Instruction,
    input  logic [NBits-1:0]    PC_4,
    input  logic [NBits-1:0]    RsData,
    input  logic [NBits-1:0]    RtData,
    input  logic                ID_EX_MemRead,
    input  logic                ID_EX_RegWrite,
    input  logic [4:0]          ID_EX_WriteReg,
    input  logic                EX_MEM_MemRead,
    input  logic [4:0]          EX_MEM_WriteReg,
    output logic                PCWrite,
    output logic                PCSelector,
    output logic [NBits-1:0]    BranchOrJumpAddress,
    output logic [NBits-1:0]    IFID_Instruction,
    output logic [NBits-1:0]    IFID_PC_4,
    output logic                ID_EX_Bubble,
    output logic [CNT_BITS-1:0] StallCount,
    output logic [CNT_BITS-1:0] FlushCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [NBits-1:0]    r_ifid_instr;
    logic [NBits-1:0]    r_ifid_pc4;
    logic [CNT_BITS-1:0] r_stall_cnt;
    logic [CNT_BITS-1:0] r_flush_cnt;

    logic [5:0]       w_op;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [5:0]       w_funct;
    logic             w_is_beq;
    logic             w_is_bne;
    logic             w_is_j;
    logic             w_is_jal;
    logic             w_is_jr;
    logic [NBits-1:0] w_br_off;
    logic [NBits-1:0] w_target;
    logic             w_taken;
    logic             w_load_use;
    logic             w_branch_hz;
    logic             w_stall;
    logic             w_flush;

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic f_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    assign w_op     = r_ifid_instr[31:26];
    assign w_rs     = r_ifid_instr[25:21];
    assign w_rt     = r_ifid_instr[20:16];
    assign w_funct  = r_ifid_instr[5:0];
    assign w_is_beq = (w_op == OP_BEQ);
    assign w_is_bne = (w_op == OP_BNE);
    assign w_is_j   = (w_op == OP_J);
    assign w_is_jal = (w_op == OP_JAL);
    assign w_is_jr  = (w_op == OP_RTYPE) && (w_funct == FN_JR);
    assign w_br_off = {{(NBits-18){r_ifid_instr[15]}}, r_ifid_instr[15:0], 2'b00};

    // Redirect target for whichever control-transfer sits in ID.
    always_comb begin
        w_target = '0;
        if (w_is_beq || w_is_bne) begin
            w_target = r_ifid_pc4 + w_br_off;
        end else if (w_is_j || w_is_jal) begin
            w_target = {r_ifid_pc4[NBits-1:28], r_ifid_instr[25:0], 2'b00};
        end else if (w_is_jr) begin
            w_target = RsData;
        end
    end

    assign w_taken = (w_is_beq && (RsData == RtData)) ||
                     (w_is_bne && (RsData != RtData)) ||
                     w_is_j || w_is_jal || w_is_jr;

    // Any consumer of a load result in EX must wait one cycle.
    assign w_load_use = ID_EX_MemRead &&
                        (f_hit(ID_EX_WriteReg, w_rs) || f_hit(ID_EX_WriteReg, w_rt));

    // Branches compare in ID, so operands still in EX (ALU) or MEM (load) must settle.
    assign w_branch_hz =
        ((w_is_beq || w_is_bne) &&
         ((ID_EX_RegWrite && (f_hit(ID_EX_WriteReg, w_rs) || f_hit(ID_EX_WriteReg, w_rt))) ||
          (EX_MEM_MemRead && (f_hit(EX_MEM_WriteReg, w_rs) || f_hit(EX_MEM_WriteReg, w_rt))))) ||
        (w_is_jr &&
         ((ID_EX_RegWrite && f_hit(ID_EX_WriteReg, w_rs)) ||
          (EX_MEM_MemRead && f_hit(EX_MEM_WriteReg, w_rs))));

    // Stall wins over a redirect: a stalled branch may still be reading stale operands.
    assign w_stall = w_load_use || w_branch_hz;
    assign w_flush = w_taken && !w_stall;

    assign PCWrite             = !w_stall;
    assign PCSelector          = w_flush;
    assign ID_EX_Bubble        = w_stall;
    assign BranchOrJumpAddress = w_target;
    assign IFID_Instruction    = r_ifid_instr;
    assign IFID_PC_4           = r_ifid_pc4;
    assign StallCount          = r_stall_cnt;
    assign FlushCount          = r_flush_cnt;

    // IF/ID register: hold on stall, squash to NOP on redirect, else advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
        end else if (w_stall) begin
            r_ifid_instr <= r_ifid_instr;
            r_ifid_pc4   <= r_ifid_pc4;
        end else if (w_flush) begin
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
        end else begin
            r_ifid_instr <= Instruction;
            r_ifid_pc4   <= PC_4;
        end
    end

    // Saturating event counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
